// File: rtl/urng_pkg.sv
// Shared types and constants for the Tausworthe URNG blocks.
package urng_pkg;

  typedef enum logic [1:0] {
    stLoad   = 2'd0,
    stWarmup = 2'd1,
    stRun    = 2'd2
  } urngState_t;

  localparam logic [31:0] SanMask0  = 32'h0000_0002;
  localparam logic [31:0] SanMask1  = 32'h0000_0008;
  localparam logic [31:0] SanMask2  = 32'h0000_0010;

  localparam logic [31:0] StepMask0 = 32'hFFFF_FFFE;
  localparam logic [31:0] StepMask1 = 32'hFFFF_FFF8;
  localparam logic [31:0] StepMask2 = 32'hFFFF_FFF0;

endpackage

// File: rtl/urng_taus_step.sv
// Purely combinational single step of the three-component Tausworthe generator.
module urng_taus_step
  import urng_pkg::*;
(
  input  logic [31:0] iS0,
  input  logic [31:0] iS1,
  input  logic [31:0] iS2,
  output logic [31:0] oS0,
  output logic [31:0] oS1,
  output logic [31:0] oS2,
  output logic [31:0] oWord
);

  always_comb begin
    oS0   = ((iS0 & StepMask0) << 12) ^ (((iS0 << 13) ^ iS0) >> 19);
    oS1   = ((iS1 & StepMask1) << 4)  ^ (((iS1 << 2)  ^ iS1) >> 25);
    oS2   = ((iS2 & StepMask2) << 17) ^ (((iS2 << 3)  ^ iS2) >> 11);
    oWord = oS0 ^ oS1 ^ oS2;
  end

endmodule

// File: rtl/urng_arbiter.sv
// Round-robin sharing of one Tausworthe URNG among NUM_REQ requesters, with seeding FSM.
// Define URNG_ARB_WARMUP_EN to build the WARMUP state that discards WARMUP_CYCLES steps per load.
module urng_arbiter
  import urng_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter logic [31:0] SEED1         = 32'h0000_1234,
  parameter logic [31:0] SEED2         = 32'h0000_5678,
  parameter logic [31:0] SEED3         = 32'h0000_9ABC,
  parameter int unsigned WARMUP_CYCLES = 16,
  localparam int unsigned IdW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iSeed_valid,
  output logic               oSeed_ready,
  input  logic [31:0]        iSeed1,
  input  logic [31:0]        iSeed2,
  input  logic [31:0]        iSeed3,
  input  logic [NUM_REQ-1:0] iReq,
  output logic [NUM_REQ-1:0] oGrant,
  output logic               oValid,
  output logic [31:0]        oData,
  output logic [IdW-1:0]     oReq_id,
  output logic               oBusy
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || WARMUP_CYCLES < 1 || WARMUP_CYCLES > 65535) begin : gBadConfig
    $error("urng_arbiter: parameter out of range");
  end

  urngState_t  state;
  logic [31:0] s0, s1, s2;
  logic [31:0] nS0, nS1, nS2, stepWord;
  logic [31:0] seed1Reg, seed2Reg, seed3Reg;
  logic [IdW-1:0] rrPtr, pickIdx;
  logic        anyReq, seedFire;
  int unsigned cand;

`ifdef URNG_ARB_WARMUP_EN
  localparam logic [15:0] WarmLast = 16'(WARMUP_CYCLES - 1);
  logic [15:0] warmCnt;
`endif

  urng_taus_step uStep (
    .iS0   (s0),
    .iS1   (s1),
    .iS2   (s2),
    .oS0   (nS0),
    .oS1   (nS1),
    .oS2   (nS2),
    .oWord (stepWord)
  );

  assign oSeed_ready = (state != stLoad);
  assign seedFire    = iSeed_valid && oSeed_ready;
  assign oValid      = |oGrant;
  assign oBusy       = (state != stRun);

  // First requesting index after rrPtr, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    anyReq  = 1'b0;
    pickIdx = '0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(rrPtr) + i) % NUM_REQ;
      if (!anyReq && iReq[IdW'(cand)]) begin
        anyReq  = 1'b1;
        pickIdx = IdW'(cand);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state    <= stLoad;
      seed1Reg <= SEED1;
      seed2Reg <= SEED2;
      seed3Reg <= SEED3;
      s0       <= '0;
      s1       <= '0;
      s2       <= '0;
      rrPtr    <= IdW'(NUM_REQ - 1);
      oGrant   <= '0;
      oData    <= '0;
      oReq_id  <= '0;
`ifdef URNG_ARB_WARMUP_EN
      warmCnt  <= '0;
`endif
    end else begin
      oGrant <= '0;
      // A seed handshake pre-empts stepping and granting in the same cycle.
      if (seedFire) begin
        seed1Reg <= iSeed1;
        seed2Reg <= iSeed2;
        seed3Reg <= iSeed3;
        state    <= stLoad;
      end else begin
        case (state)
          stLoad: begin
            s0 <= seed1Reg | SanMask0;
            s1 <= seed2Reg | SanMask1;
            s2 <= seed3Reg | SanMask2;
`ifdef URNG_ARB_WARMUP_EN
            warmCnt <= '0;
            state   <= stWarmup;
`else
            state   <= stRun;
`endif
          end
`ifdef URNG_ARB_WARMUP_EN
          stWarmup: begin
            s0 <= nS0;
            s1 <= nS1;
            s2 <= nS2;
            if (warmCnt == WarmLast) state <= stRun;
            else                     warmCnt <= warmCnt + 16'd1;
          end
`endif
          stRun: begin
            if (anyReq) begin
              s0      <= nS0;
              s1      <= nS1;
              s2      <= nS2;
              oData   <= stepWord;
              oReq_id <= pickIdx;
              rrPtr   <= pickIdx;
              oGrant  <= NUM_REQ'(1) << pickIdx;
            end
          end
          default: state <= stLoad;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_urng_arbiter.sv
// Self-checking bench for urng_arbiter against a per-cycle behavioural model.
module tb_urng_arbiter;

  localparam int NR = 4;
`ifdef URNG_ARB_WARMUP_EN
  localparam int W = 4;
`else
  localparam int W = 0;
`endif

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic        iSeed_valid = 1'b0;
  logic        oSeed_ready;
  logic [31:0] iSeed1 = '0, iSeed2 = '0, iSeed3 = '0;
  logic [NR-1:0] iReq = '0;
  logic [NR-1:0] oGrant;
  logic        oValid;
  logic [31:0] oData;
  logic [1:0]  oReq_id;
  logic        oBusy;

  urng_arbiter #(
    .NUM_REQ       (NR),
    .SEED1         (32'd1),
    .SEED2         (32'd2),
    .SEED3         (32'd3),
    .WARMUP_CYCLES (4)
  ) dut (
    .iClk        (iClk),
    .iReset      (iReset),
    .iSeed_valid (iSeed_valid),
    .oSeed_ready (oSeed_ready),
    .iSeed1      (iSeed1),
    .iSeed2      (iSeed2),
    .iSeed3      (iSeed3),
    .iReq        (iReq),
    .oGrant      (oGrant),
    .oValid      (oValid),
    .oData       (oData),
    .oReq_id     (oReq_id),
    .oBusy       (oBusy)
  );

  always #5 iClk = ~iClk;

  typedef struct packed { logic [31:0] a, b, c, w; } stepRes_t;

  function automatic stepRes_t tausRef(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    stepRes_t r;
    r.a = ((a & 32'hFFFF_FFFE) << 12) ^ (((a << 13) ^ a) >> 19);
    r.b = ((b & 32'hFFFF_FFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
    r.c = ((c & 32'hFFFF_FFF0) << 17) ^ (((c << 3)  ^ c) >> 11);
    r.w = r.a ^ r.b ^ r.c;
    return r;
  endfunction

  // Output word after k steps from seeds 1,2,3.
  function automatic logic [31:0] nthWord(input int k);
    stepRes_t r;
    r = '{a: 32'd3, b: 32'd10, c: 32'h13, w: 32'd0};
    for (int i = 0; i < k; i++) r = tausRef(r.a, r.b, r.c);
    return r.w;
  endfunction

  // Behavioural model state.
  logic [31:0] mSeed1, mSeed2, mSeed3, mS0, mS1, mS2, mData;
  int          mPtr, mWarm;
  bit          mLoad;
  logic [NR-1:0] expGrant;
  logic [1:0]  expId;
  int nVec = 0, nErr = 0;

  wire logic [40:0] obsVec = {oGrant, oValid, oData, oReq_id, oSeed_ready, oBusy};
  wire logic [40:0] expVec = {expGrant, |expGrant, mData, expId, !mLoad, (mLoad || mWarm > 0)};

  task automatic cycle();
    stepRes_t r;
    int c;
    logic [1:0] ci;
    expGrant = '0;
    if (iReset) begin
      mSeed1 = 32'd1; mSeed2 = 32'd2; mSeed3 = 32'd3;
      mLoad = 1'b1; mWarm = 0; mPtr = NR - 1; mData = '0; expId = '0;
    end else if (mLoad) begin
      mS0 = mSeed1 | 32'h2; mS1 = mSeed2 | 32'h8; mS2 = mSeed3 | 32'h10;
      mLoad = 1'b0; mWarm = W;
    end else if (iSeed_valid) begin
      mSeed1 = iSeed1; mSeed2 = iSeed2; mSeed3 = iSeed3; mLoad = 1'b1;
    end else if (mWarm > 0) begin
      r = tausRef(mS0, mS1, mS2);
      mS0 = r.a; mS1 = r.b; mS2 = r.c; mWarm--;
    end else if (iReq != '0) begin
      c = 0;
      for (int k = 1; k <= NR; k++) begin
        c = (mPtr + k) % NR;
        ci = 2'(c);
        if (iReq[ci]) break;
      end
      r = tausRef(mS0, mS1, mS2);
      mS0 = r.a; mS1 = r.b; mS2 = r.c;
      mData = r.w; expId = 2'(c); mPtr = c; expGrant[2'(c)] = 1'b1;
    end
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iReset = 1'b1; iReq = 4'b1111; iSeed_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      if (obsVec !== expVec) begin nErr++; $display("FAIL reset: got %h want %h", obsVec, expVec); end
      nVec++;
    end
    if ({oGrant, oValid, oData, oReq_id, oSeed_ready, oBusy} !== {4'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1}) begin
      nErr++; $display("FAIL reset_idle: got %h", obsVec);
    end
    nVec++;
    iSeed_valid = 1'b0; iReq = '0;
  endtask

  task automatic test_known_vector();
    int n;
    iReset = 1'b0; iReq = 4'b0001; n = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(); n = i;
      if (obsVec !== expVec) begin nErr++; $display("FAIL known_cyc%0d: got %h want %h", i, obsVec, expVec); end
      nVec++;
      if (oValid) break;
    end
    if (n != 2 + W || !oValid) begin nErr++; $display("FAIL first_grant_latency: got %0d cycles want %0d", n, 2 + W); end
    nVec++;
    if (oData !== nthWord(W + 1) || oReq_id !== 2'd0) begin
      nErr++; $display("FAIL first_word: got %h id %0d want %h id 0", oData, oReq_id, nthWord(W + 1));
    end
    nVec++;
`ifndef URNG_ARB_WARMUP_EN
    if (oData !== 32'h0020_2080) begin nErr++; $display("FAIL literal_word1: got %h want 00202080", oData); end
    nVec++;
`endif
    cycle();
    if (obsVec !== expVec) begin nErr++; $display("FAIL known_second: got %h want %h", obsVec, expVec); end
    nVec++;
`ifndef URNG_ARB_WARMUP_EN
    if (oData !== 32'h0200_2C80) begin nErr++; $display("FAIL literal_word2: got %h want 02002c80", oData); end
    nVec++;
`endif
  endtask

  task automatic test_round_robin();
    logic [1:0] prev;
    iReq = 4'b1111;
    prev = oReq_id;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (obsVec !== expVec) begin nErr++; $display("FAIL rr_cyc%0d: got %h want %h", i, obsVec, expVec); end
      nVec++;
      if (!oValid || oReq_id !== prev + 2'd1) begin
        nErr++; $display("FAIL rr_order%0d: got id %0d valid %b want id %0d", i, oReq_id, oValid, prev + 2'd1);
      end
      nVec++;
      prev = oReq_id;
    end
  endtask

  task automatic test_sparse_hold();
    logic [31:0] held;
    logic [3:0] pat [0:6];
    pat = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b1010};
    held = '0;
    for (int i = 0; i < 7; i++) begin
      iReq = pat[i];
      cycle();
      if (obsVec !== expVec) begin nErr++; $display("FAIL sparse_cyc%0d: got %h want %h", i, obsVec, expVec); end
      nVec++;
      if (i == 3) held = oData;
      if (i >= 4 && i <= 5 && (oValid !== 1'b0 || oData !== held)) begin
        nErr++; $display("FAIL idle_hold%0d: got v=%b d=%h want v=0 d=%h", i, oValid, oData, held);
      end
      if (i == 6 && oReq_id !== 2'd1) begin nErr++; $display("FAIL resume_id: got %0d want 1", oReq_id); end
      if (i >= 4) nVec++;
    end
  endtask

  task automatic test_reseed_collision();
    int n;
    iSeed1 = 32'd1; iSeed2 = 32'd2; iSeed3 = 32'd3; iSeed_valid = 1'b1; iReq = 4'b0001;
    cycle();
    if (obsVec !== expVec || oValid !== 1'b0 || oSeed_ready !== 1'b0) begin
      nErr++; $display("FAIL seed_wins: got %h want %h", obsVec, expVec);
    end
    nVec++;
    iSeed_valid = 1'b0; n = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(); n = i;
      if (obsVec !== expVec) begin nErr++; $display("FAIL reseed_cyc%0d: got %h want %h", i, obsVec, expVec); end
      nVec++;
      if (oValid) break;
    end
    if (!oValid || n != 2 + W || oData !== nthWord(W + 1)) begin
      nErr++; $display("FAIL reseed_first: got %h after %0d want %h after %0d", oData, n, nthWord(W + 1), 2 + W);
    end
    nVec++;
  endtask

  task automatic test_reseed_warmup();
    int n;
    iReq = '0; iSeed_valid = 1'b1;
    iSeed1 = $urandom; iSeed2 = $urandom; iSeed3 = $urandom;
    for (int i = 0; i < 3; i++) begin
      cycle();
      iSeed_valid = 1'b0;
      if (obsVec !== expVec) begin nErr++; $display("FAIL warm_pre%0d: got %h want %h", i, obsVec, expVec); end
      nVec++;
    end
    iSeed_valid = 1'b1; iReq = 4'b0100;
    iSeed1 = $urandom; iSeed2 = $urandom; iSeed3 = $urandom;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(); n = i;
      iSeed_valid = 1'b0;
      if (obsVec !== expVec) begin nErr++; $display("FAIL warm_cyc%0d: got %h want %h", i, obsVec, expVec); end
      nVec++;
      if (oValid) break;
    end
    if (!oValid || n != 3 + W) begin nErr++; $display("FAIL warm_restart: got %0d cycles want %0d", n, 3 + W); end
    nVec++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      iReq = 4'($urandom);
      iSeed_valid = ($urandom_range(0, 19) == 0);
      iSeed1 = $urandom; iSeed2 = $urandom; iSeed3 = $urandom;
      iReset = ($urandom_range(0, 99) == 0);
      cycle();
      if (obsVec !== expVec) begin nErr++; $display("FAIL random_cyc%0d: got %h want %h", i, obsVec, expVec); end
      nVec++;
    end
    iReset = 1'b0; iSeed_valid = 1'b0; iReq = '0;
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_round_robin();
    test_sparse_hold();
    test_reseed_collision();
    test_reseed_warmup();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/urng_arbiter.md
# urng_arbiter

Round-robin scheduler that owns a single Tausworthe URNG stepping core and shares its 32-bit output among NUM_REQ requesters. It also sequences seeding: reset-time default seeds, runtime reseed handshake, seed sanitisation and an optional warm-up discard. It sits between the Tausworthe datapath and the noise/sample consumers, so that each delivered number is consumed by exactly one requester.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- SEED1 / SEED2 / SEED3, 32'h0000_1234 / 32'h0000_5678 / 32'h0000_9ABC: seeds loaded on reset.
- WARMUP_CYCLES, 16: generator steps discarded after every seed load. Only used with the warm-up macro; range 1..65535.
- iClk, in, 1: single clock; all logic on the rising edge.
- iReset, in, 1: synchronous, active-high reset.
- iSeed_valid, in, 1: reseed request.
- oSeed_ready, out, 1: reseed can be accepted.
- iSeed1 / iSeed2 / iSeed3, in, 32 each: new seeds, sampled on seed handshake.
- iReq, in, NUM_REQ: level request per requester.
- oGrant, out, NUM_REQ: one-hot grant, registered.
- oValid, out, 1: oData/oReq_id valid; equals |oGrant.
- oData, out, 32: delivered random word.
- oReq_id, out, $clog2(NUM_REQ): index of the granted requester.
- oBusy, out, 1: high in LOAD or WARMUP.

## Operation
- State: three 32-bit words S0, S1, S2.
- One step per advance:
  - S0' = ((S0 & FFFF_FFFE) << 12) ^ (((S0 << 13) ^ S0) >> 19)
  - S1' = ((S1 & FFFF_FFF8) << 4) ^ (((S1 << 2) ^ S1) >> 25)
  - S2' = ((S2 & FFFF_FFF0) << 17) ^ (((S2 << 3) ^ S2) >> 11)
  - Output = S0' ^ S1' ^ S2'. All arithmetic is 32-bit; shifted-out bits are dropped.
- Seed sanitisation, applied on every load (reset or handshake): S0 = seed1 | 32'h2, S1 = seed2 | 32'h8, S2 = seed3 | 32'h10.
- FSM states:
  - LOAD: sanitise and write S0..S2. Lasts 1 cycle, then goes to WARMUP (macro on) or RUN (macro off).
  - WARMUP: step every cycle without granting. A counter runs from 0 to WARMUP_CYCLES-1, then the FSM goes to RUN.
  - RUN: each cycle with iReq != 0, grant one requester, step once, and register the output. No request means no step; the state holds.
- Arbitration: round-robin. Search starts at last_grant+1 and wraps at NUM_REQ-1 → 0. The pointer updates only on a grant.
- Seed handshake fires when iSeed_valid & oSeed_ready. oSeed_ready = 1 in WARMUP and RUN, 0 in LOAD. The handshake captures the seeds and goes to LOAD from any state.
- Seed handshake in the same cycle as a RUN request: the seed wins. No grant and no step that cycle; the RR pointer is unchanged.
- Reseed during WARMUP: the warm-up counter restarts after the new LOAD.
- iReq is not required to drop after a grant. A held request is re-granted when the RR order comes back to it.

## Timing
- Reset (synchronous): the FSM enters LOAD with SEED1..3, RR pointer = NUM_REQ-1 (so requester 0 is first).
- Output values during reset and the following cycle: oGrant=0, oValid=0, oData=0, oReq_id=0, oSeed_ready=0, oBusy=1.
- Grant latency: iReq sampled at edge t gives oGrant/oValid/oData/oReq_id at t+1, valid for exactly one cycle.
- Throughput: one word per cycle in RUN.
- First possible grant:
  - Macro off: iReq sampled on the edge that leaves LOAD → outputs 1 cycle later. Minimum 2 cycles after reset deasserts.
  - Macro on: WARMUP_CYCLES cycles later than with the macro off.
- oData holds its last value when oValid=0.

## Configuration
- URNG_ARB_WARMUP_EN defined: the WARMUP state and its 16-bit counter are built in. WARMUP_CYCLES steps are discarded after every load.
- URNG_ARB_WARMUP_EN undefined: LOAD goes directly to RUN. WARMUP_CYCLES is ignored. oBusy is high only in LOAD.

## Structure
- Package urng_pkg holds:
  - the FSM state enum (LOAD, WARMUP, RUN)
  - the sanitise masks 32'h2, 32'h8, 32'h10
  - the step masks FFFF_FFFE / FFFF_FFF8 / FFFF_FFF0
- Sub-module urng_taus_step: purely combinational single step (S0..S2 in → S0'..S2' and output word). It is instantiated once and reusable by other URNG blocks.
- Arbiter, FSM, counter and output registers live in urng_arbiter.

## Test plan
- Macro off, SEED1..3 = 1,2,3, reset then iReq=4'b0001 held → first oData=32'h0020_2080 with oReq_id=0, next oData=32'h0200_2C80.
- iReq=4'b1111 held in RUN → oReq_id sequence 0,1,2,3,0 on consecutive cycles, oValid continuously 1.
- iReq=4'b1010 after last grant to 1 → grant 3, then 1, then 3. Dropping iReq to 0 → oValid=0, oData unchanged, state frozen (next grant continues the sequence).
- Seed handshake with iSeed1..3 = 1,2,3 in the same cycle as iReq=4'b0001 → no grant that cycle, oSeed_ready=0 for 1 cycle. First subsequent oData=32'h0020_2080.
- Macro on, WARMUP_CYCLES=4, reset with iReq held → oBusy high, no grant until 5 cycles after leaving reset. The first word equals the 5th step output of the macro-off run.
- Reseed in the 2nd WARMUP cycle → the warm-up counter restarts; exactly WARMUP_CYCLES discards follow the new LOAD.
